// File: rtl/farm_sensor.sv
// Farm-road vehicle sensor: synchronizes and debounces the loop detector, tracks
// the waiting-vehicle queue, and flags queue overflow and illegal lamp states.
module farm_sensor #(
    parameter int DEBOUNCE = 4,
    parameter int DEPART   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_raw,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    output logic       sensor,
    output logic [3:0] queue_cnt,
    output logic       overflow,
    output logic       conflict
);
    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b001;
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(DEPART + 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          sensor_q, sensor_d;
    logic          ovf_q, ovf_d;
    logic          cfl_q, cfl_d;
    logic          arrive, depart, hw_ok, fm_ok, bad_lamp;

    always_comb begin
        sync1_d = loop_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        stab_d  = '0;
        arrive  = 1'b0;
        if (sync2_q != deb_q) begin
            if (stab_q == SW'(DEBOUNCE - 1)) begin
                deb_d  = sync2_q;
                arrive = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Timer only runs while someone is waiting and the farm road has GREEN.
    always_comb begin
        tmr_d  = '0;
        depart = 1'b0;
        if (light_farm == GRN && cnt_q != 4'd0) begin
            if (tmr_q == TW'(DEPART - 1)) begin
                depart = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (arrive && cnt_q == 4'd15) ovf_d = 1'b1;
        if (arrive && !depart && cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
        else if (depart && !arrive) cnt_d = cnt_q - 4'd1;
        sensor_d = (cnt_d != 4'd0);
    end

    always_comb begin
        hw_ok    = (light_highway == GRN) || (light_highway == YEL) || (light_highway == RED);
        fm_ok    = (light_farm == GRN) || (light_farm == YEL) || (light_farm == RED);
        bad_lamp = !hw_ok || !fm_ok
                 || (light_highway == GRN && light_farm != RED)
                 || (light_farm == GRN && light_highway != RED);
        cfl_d    = cfl_q | bad_lamp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            stab_q   <= '0;
            tmr_q    <= '0;
            cnt_q    <= 4'd0;
            sensor_q <= 1'b0;
            ovf_q    <= 1'b0;
            cfl_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            stab_q   <= stab_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            sensor_q <= sensor_d;
            ovf_q    <= ovf_d;
            cfl_q    <= cfl_d;
        end
    end

    assign sensor    = sensor_q;
    assign queue_cnt = cnt_q;
    assign overflow  = ovf_q;
    assign conflict  = cfl_q;
endmodule
